// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Shared definitions for the IFU fetch queue: default instruction/PC width,
//   the NOP encoding shown to decode while the queue is empty, the storage
//   entry width and an occupancy classification used by the control logic.
package fetch_queue_pkg;

  localparam int unsigned IFQ_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] IFQ_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } ifq_occ_e;

  // One entry holds {instruction, pc, pc_plus_4}.
  function automatic int unsigned ifq_entry_width(input int unsigned xlen);
    return 3 * xlen;
  endfunction

  function automatic ifq_occ_e ifq_occ(input int unsigned occ, input int unsigned depth);
    if (occ == 0)          return OCC_EMPTY;
    else if (occ >= depth) return OCC_FULL;
    else                   return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// ifq_ram
//   DEPTH x WIDTH storage for the fetch queue. One synchronous write port,
//   one asynchronous read port. The array itself is not reset; validity is
//   tracked by the pointers/occupancy in fetch_queue.
// Ports
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
module ifq_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   Receiving end of the IFU fetch interface. Captures {Instruction_Code, PC,
//   PC_plus_4} every non-reset cycle into a DEPTH-entry FIFO and presents the
//   head to decode over valid/ready. Stalls the IFU while full so a held PC is
//   neither lost nor duplicated; a flush discards every wrong-path entry.
// Configuration macro
//   IFQ_BYPASS_EN  when defined and the queue is empty, the IFU word is
//                  presented to decode in the same cycle and, if accepted,
//                  never written into storage.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   Instruction_Code    IFU instruction word
//   PC, PC_plus_4       IFU PC and PC+4 for that word
//   flush               redirect this cycle (branch/jump taken)
//   stall               to IFU: hold PC (queue full)
//   dec_valid/ready     handshake toward decode
//   dec_instr/pc/pc_plus_4  head entry (NOP/0 when nothing valid)
//   count               occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN  = IFQ_XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        Instruction_Code,
  input  logic [XLEN-1:0]        PC,
  input  logic [XLEN-1:0]        PC_plus_4,
  input  logic                   flush,
  output logic                   stall,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [XLEN-1:0]        dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic [XLEN-1:0]        dec_pc_plus_4,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = ifq_entry_width(XLEN);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;
  ifq_occ_e        occ_state;
  logic            store_valid;
  logic            bypass;
  logic            enq;
  logic            deq;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head;

  assign occ_state = ifq_occ(32'(occ), DEPTH);

  // Depends only on registered occupancy: no path from dec_ready to the IFU.
  assign stall = (occ_state == OCC_FULL);

  // A flushed head is wrong-path; reset discards everything like a flush.
  assign store_valid = (occ_state != OCC_EMPTY) && !flush && !reset;

`ifdef IFQ_BYPASS_EN
  assign bypass = (occ_state == OCC_EMPTY) && !flush && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign dec_valid = store_valid | bypass;
  assign deq       = store_valid & dec_ready;

  // A bypassed word taken by decode this cycle is consumed without storage.
  assign enq = !reset && !flush && (occ_state != OCC_FULL) && !(bypass && dec_ready);

  assign wr_entry = {Instruction_Code, PC, PC_plus_4};

  ifq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    dec_instr     = XLEN'(IFQ_NOP);
    dec_pc        = '0;
    dec_pc_plus_4 = '0;
    if (store_valid) begin
      dec_instr     = head[3*XLEN-1:2*XLEN];
      dec_pc        = head[2*XLEN-1:XLEN];
      dec_pc_plus_4 = head[XLEN-1:0];
    end else if (bypass) begin
      dec_instr     = Instruction_Code;
      dec_pc        = PC;
      dec_pc_plus_4 = PC_plus_4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      // DEPTH is a power of two, so AW-bit pointers wrap on their own.
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + CW'(enq) - CW'(deq);
    end
  end

  assign count = occ;

endmodule
